riscv_bpu: RTL and testbench

//  Branch prediction unit: fetch-side counterpart of the execute-stage branch comparator.
//  - Fetch: a direct-mapped BTB with 2-bit saturating counters predicts taken/target for the fetch PC.
//  - Execute: the resolved outcome (comparator taken flag, computed target) trains the table.
//  - Execute: a misprediction raises a flush with the corrected PC.

---
 rtl/riscv_bpu_if.sv | 73 +++++++
 rtl/riscv_bpu.sv | 171 +++++++++++++++++
 tb/tb_riscv_bpu.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/riscv_bpu_if.sv
// ---------------------------------------------------------------------------
// riscv_bpu_if
// Purpose : bundles the fetch-side predict port and the execute-side
//           train/flush port of the branch prediction unit.
// Signals :
//   i_riscv_bpu_fetch_pc        fetch PC looked up this cycle
//   o_riscv_bpu_pred_taken      predicted taken (combinational)
//   o_riscv_bpu_pred_target     predicted target, 0 when not predicted taken
//   i_riscv_bpu_upd_*           resolving branch/jump from execute
//   o_riscv_bpu_mispredict      registered flush request
//   o_riscv_bpu_correct_pc      registered redirect PC
//   o_riscv_bpu_branch_cnt      (RISCV_BPU_STATS_EN only) resolved branches
//   o_riscv_bpu_mispred_cnt     (RISCV_BPU_STATS_EN only) mispredictions
// Modports: master = pipeline side, slave = BPU side.
// ---------------------------------------------------------------------------
interface riscv_bpu_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] i_riscv_bpu_fetch_pc;
  logic            o_riscv_bpu_pred_taken;
  logic [XLEN-1:0] o_riscv_bpu_pred_target;
  logic            i_riscv_bpu_upd_valid;
  logic [XLEN-1:0] i_riscv_bpu_upd_pc;
  logic            i_riscv_bpu_upd_compressed;
  logic            i_riscv_bpu_upd_taken;
  logic [XLEN-1:0] i_riscv_bpu_upd_target;
  logic            i_riscv_bpu_upd_pred_taken;
  logic [XLEN-1:0] i_riscv_bpu_upd_pred_target;
  logic            o_riscv_bpu_mispredict;
  logic [XLEN-1:0] o_riscv_bpu_correct_pc;
`ifdef RISCV_BPU_STATS_EN
  logic [31:0]     o_riscv_bpu_branch_cnt;
  logic [31:0]     o_riscv_bpu_mispred_cnt;
`endif

  modport master (
    output i_riscv_bpu_fetch_pc,
    input  o_riscv_bpu_pred_taken,
    input  o_riscv_bpu_pred_target,
    output i_riscv_bpu_upd_valid,
    output i_riscv_bpu_upd_pc,
    output i_riscv_bpu_upd_compressed,
    output i_riscv_bpu_upd_taken,
    output i_riscv_bpu_upd_target,
    output i_riscv_bpu_upd_pred_taken,
    output i_riscv_bpu_upd_pred_target,
    input  o_riscv_bpu_mispredict,
`ifdef RISCV_BPU_STATS_EN
    input  o_riscv_bpu_branch_cnt,
    input  o_riscv_bpu_mispred_cnt,
`endif
    input  o_riscv_bpu_correct_pc
  );

  modport slave (
    input  i_riscv_bpu_fetch_pc,
    output o_riscv_bpu_pred_taken,
    output o_riscv_bpu_pred_target,
    input  i_riscv_bpu_upd_valid,
    input  i_riscv_bpu_upd_pc,
    input  i_riscv_bpu_upd_compressed,
    input  i_riscv_bpu_upd_taken,
    input  i_riscv_bpu_upd_target,
    input  i_riscv_bpu_upd_pred_taken,
    input  i_riscv_bpu_upd_pred_target,
    output o_riscv_bpu_mispredict,
`ifdef RISCV_BPU_STATS_EN
    output o_riscv_bpu_branch_cnt,
    output o_riscv_bpu_mispred_cnt,
`endif
    output o_riscv_bpu_correct_pc
  );
endinterface

// File: rtl/riscv_bpu.sv
// ---------------------------------------------------------------------------
// riscv_bpu
// Purpose : branch prediction unit. A direct-mapped BTB with 2-bit
//           saturating counters predicts taken/target for the fetch PC
//           (0-cycle latency); the execute-stage resolution trains the table
//           and a detected misprediction raises a registered flush with the
//           corrected PC.
// Ports   :
//   i_riscv_clk    clock, all state changes on the rising edge
//   i_riscv_rst_n  synchronous active-low reset
//   bpu            riscv_bpu_if.slave (predict, update and flush signals)
// Optional: define RISCV_BPU_STATS_EN to add 32-bit wrapping branch and
//           misprediction counters on the interface.
// ---------------------------------------------------------------------------
module riscv_bpu #(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 16
) (
  input logic        i_riscv_clk,
  input logic        i_riscv_rst_n,
  riscv_bpu_if.slave bpu
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 1;

  // Saturating counter increment, holds at 2'b11.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    ctr_inc = (c == 2'b11) ? 2'b11 : (c + 2'b01);
  endfunction

  // Saturating counter decrement, holds at 2'b00.
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    ctr_dec = (c == 2'b00) ? 2'b00 : (c - 2'b01);
  endfunction

  // Table storage; target bit 0 is implicitly zero and not stored.
  logic             valid_r  [ENTRIES];
  logic [TAG_W-1:0] tag_r    [ENTRIES];
  logic [XLEN-1:1]  target_r [ENTRIES];
  logic [1:0]       ctr_r    [ENTRIES];

  logic             mispredict_r;
  logic [XLEN-1:0]  correct_pc_r;

  logic [IDX_W-1:0] fetch_idx_s;
  logic [TAG_W-1:0] fetch_tag_s;
  logic             fetch_hit_s;
  logic             pred_taken_s;
  logic [XLEN-1:0]  pred_target_s;

  logic [IDX_W-1:0] upd_idx_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic             upd_hit_s;
  logic             mispredict_s;
  logic [XLEN-1:0]  correct_pc_s;
  logic [XLEN-1:0]  seq_pc_s;

  // Fetch PC bit 0 never selects an entry (instructions are halfword aligned).
  logic unused_s;
  assign unused_s = bpu.i_riscv_bpu_fetch_pc[0];

  // Prediction lookup: reads the pre-edge table, so a same-cycle update to
  // the same entry is not visible until the next cycle.
  always_comb begin
    fetch_idx_s   = bpu.i_riscv_bpu_fetch_pc[IDX_W:1];
    fetch_tag_s   = bpu.i_riscv_bpu_fetch_pc[XLEN-1:IDX_W+1];
    fetch_hit_s   = valid_r[fetch_idx_s] & (tag_r[fetch_idx_s] == fetch_tag_s);
    pred_taken_s  = 1'b0;
    pred_target_s = {XLEN{1'b0}};
    if (!i_riscv_rst_n) begin
      pred_taken_s  = 1'b0;
      pred_target_s = {XLEN{1'b0}};
    end else if (fetch_hit_s & ctr_r[fetch_idx_s][1]) begin
      pred_taken_s  = 1'b1;
      pred_target_s = {target_r[fetch_idx_s], 1'b0};
    end else begin
      pred_taken_s  = 1'b0;
      pred_target_s = {XLEN{1'b0}};
    end
  end

  // Update-side lookup and misprediction detection.
  always_comb begin
    upd_idx_s    = bpu.i_riscv_bpu_upd_pc[IDX_W:1];
    upd_tag_s    = bpu.i_riscv_bpu_upd_pc[XLEN-1:IDX_W+1];
    upd_hit_s    = valid_r[upd_idx_s] & (tag_r[upd_idx_s] == upd_tag_s);
    // Fall-through address wraps modulo 2^XLEN.
    seq_pc_s     = bpu.i_riscv_bpu_upd_pc +
                   (bpu.i_riscv_bpu_upd_compressed ? {{(XLEN-3){1'b0}}, 3'd2}
                                                   : {{(XLEN-3){1'b0}}, 3'd4});
    mispredict_s = bpu.i_riscv_bpu_upd_valid &
                   ((bpu.i_riscv_bpu_upd_pred_taken != bpu.i_riscv_bpu_upd_taken) |
                    (bpu.i_riscv_bpu_upd_taken &
                     (bpu.i_riscv_bpu_upd_pred_target != bpu.i_riscv_bpu_upd_target)));
    if (bpu.i_riscv_bpu_upd_taken) begin
      correct_pc_s = bpu.i_riscv_bpu_upd_target;
    end else begin
      correct_pc_s = seq_pc_s;
    end
  end

  // Table training: strengthen/retarget on taken hit, allocate on taken miss,
  // weaken on not-taken hit, ignore not-taken miss.
  always_ff @(posedge i_riscv_clk) begin
    if (!i_riscv_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {(XLEN-1){1'b0}};
        ctr_r[i]    <= 2'b01;
      end
    end else if (bpu.i_riscv_bpu_upd_valid) begin
      if (bpu.i_riscv_bpu_upd_taken) begin
        target_r[upd_idx_s] <= bpu.i_riscv_bpu_upd_target[XLEN-1:1];
        if (upd_hit_s) begin
          ctr_r[upd_idx_s] <= ctr_inc(ctr_r[upd_idx_s]);
        end else begin
          valid_r[upd_idx_s] <= 1'b1;
          tag_r[upd_idx_s]   <= upd_tag_s;
          ctr_r[upd_idx_s]   <= 2'b10;
        end
      end else if (upd_hit_s) begin
        ctr_r[upd_idx_s] <= ctr_dec(ctr_r[upd_idx_s]);
      end
    end
  end

  // Flush request: one-cycle pulse per mispredicted resolution; the redirect
  // PC is only reloaded on a mispredict and otherwise holds.
  always_ff @(posedge i_riscv_clk) begin
    if (!i_riscv_rst_n) begin
      mispredict_r <= 1'b0;
      correct_pc_r <= {XLEN{1'b0}};
    end else begin
      mispredict_r <= mispredict_s;
      if (mispredict_s) begin
        correct_pc_r <= correct_pc_s;
      end
    end
  end

`ifdef RISCV_BPU_STATS_EN
  logic [31:0] branch_cnt_r;
  logic [31:0] mispred_cnt_r;

  // Statistics counters, wrapping at 2^32.
  always_ff @(posedge i_riscv_clk) begin
    if (!i_riscv_rst_n) begin
      branch_cnt_r  <= 32'd0;
      mispred_cnt_r <= 32'd0;
    end else begin
      if (bpu.i_riscv_bpu_upd_valid) begin
        branch_cnt_r <= branch_cnt_r + 32'd1;
      end
      if (mispredict_s) begin
        mispred_cnt_r <= mispred_cnt_r + 32'd1;
      end
    end
  end

  assign bpu.o_riscv_bpu_branch_cnt  = branch_cnt_r;
  assign bpu.o_riscv_bpu_mispred_cnt = mispred_cnt_r;
`endif

  assign bpu.o_riscv_bpu_pred_taken  = pred_taken_s;
  assign bpu.o_riscv_bpu_pred_target = pred_target_s;
  assign bpu.o_riscv_bpu_mispredict  = mispredict_r;
  assign bpu.o_riscv_bpu_correct_pc  = correct_pc_r;

endmodule

// File: tb/tb_riscv_bpu.sv
// ---------------------------------------------------------------------------
// tb_riscv_bpu
// Directed, table-driven bench for riscv_bpu (XLEN=64, ENTRIES=16). Each
// vector is driven at the falling edge; the combinational prediction is
// compared before the rising edge and the registered flush after it.
// ---------------------------------------------------------------------------
module tb_riscv_bpu;

  localparam int XLEN = 64;
  localparam int NVEC = 19;

  typedef struct {
    logic [63:0] fetch_pc;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_compressed;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        upd_pred_taken;
    logic [63:0] upd_pred_target;
    logic        exp_pred_taken;
    logic [63:0] exp_pred_target;
    logic        exp_mispredict;
    logic [63:0] exp_correct_pc;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  int   exp_branches;
  int   exp_mispreds;
  vec_t vec [NVEC];

  riscv_bpu_if #(.XLEN(XLEN)) bpu_if ();

  riscv_bpu #(.XLEN(XLEN), .ENTRIES(16)) dut (
    .i_riscv_clk   (clk),
    .i_riscv_rst_n (rst_n),
    .bpu           (bpu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle(input logic [63:0] fpc);
    bpu_if.i_riscv_bpu_fetch_pc        = fpc;
    bpu_if.i_riscv_bpu_upd_valid       = 1'b0;
    bpu_if.i_riscv_bpu_upd_pc          = 64'h0;
    bpu_if.i_riscv_bpu_upd_compressed  = 1'b0;
    bpu_if.i_riscv_bpu_upd_taken       = 1'b0;
    bpu_if.i_riscv_bpu_upd_target      = 64'h0;
    bpu_if.i_riscv_bpu_upd_pred_taken  = 1'b0;
    bpu_if.i_riscv_bpu_upd_pred_target = 64'h0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    exp_branches = 0;
    exp_mispreds = 0;

    //            fetch        uv    upc                   cmp   tk    target       ptk   ptarget      e_ptk e_ptgt       e_mp  e_cpc
    vec[0]  = '{64'h1000, 1'b0, 64'h0,                 1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h0};
    vec[1]  = '{64'h1000, 1'b1, 64'h1000,              1'b0, 1'b1, 64'h2000, 1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 64'h2000};
    vec[2]  = '{64'h1000, 1'b0, 64'h0,                 1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 64'h2000, 1'b0, 64'h2000};
    vec[3]  = '{64'h1020, 1'b0, 64'h0,                 1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h2000};
    vec[4]  = '{64'h1000, 1'b1, 64'h1000,              1'b0, 1'b0, 64'h2000, 1'b1, 64'h2000, 1'b1, 64'h2000, 1'b1, 64'h1004};
    vec[5]  = '{64'h1000, 1'b1, 64'h1000,              1'b0, 1'b0, 64'h2000, 1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h1004};
    vec[6]  = '{64'h1000, 1'b1, 64'h1000,              1'b0, 1'b0, 64'h2000, 1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h1004};
    vec[7]  = '{64'h1000, 1'b1, 64'h1000,              1'b0, 1'b1, 64'h2000, 1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 64'h2000};
    vec[8]  = '{64'h1000, 1'b0, 64'h0,                 1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h2000};
    vec[9]  = '{64'h1000, 1'b1, 64'h1000,              1'b0, 1'b1, 64'h2000, 1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 64'h2000};
    vec[10] = '{64'h1000, 1'b1, 64'h1000,              1'b0, 1'b1, 64'h2000, 1'b1, 64'h2000, 1'b1, 64'h2000, 1'b0, 64'h2000};
    vec[11] = '{64'h1000, 1'b1, 64'h1000,              1'b0, 1'b1, 64'h2400, 1'b1, 64'h2000, 1'b1, 64'h2000, 1'b1, 64'h2400};
    vec[12] = '{64'h1000, 1'b0, 64'h0,                 1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 64'h2400, 1'b0, 64'h2400};
    vec[13] = '{64'h1000, 1'b1, 64'h1000,              1'b0, 1'b0, 64'h2400, 1'b1, 64'h2400, 1'b1, 64'h2400, 1'b1, 64'h1004};
    vec[14] = '{64'h1000, 1'b0, 64'h0,                 1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 64'h2400, 1'b0, 64'h1004};
    vec[15] = '{64'h3002, 1'b1, 64'h3002,              1'b1, 1'b0, 64'h3100, 1'b1, 64'h3100, 1'b0, 64'h0,    1'b1, 64'h3004};
    vec[16] = '{64'h3002, 1'b1, 64'h3002,              1'b1, 1'b1, 64'h3100, 1'b1, 64'h3100, 1'b0, 64'h0,    1'b0, 64'h3004};
    vec[17] = '{64'h3002, 1'b0, 64'h0,                 1'b0, 1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 64'h3100, 1'b0, 64'h3004};
    vec[18] = '{64'h1000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h10, 1'b1, 64'h10,   1'b1, 64'h2400, 1'b1, 64'h0};

    // Reset phase: prediction must be forced low even while in reset.
    rst_n = 1'b0;
    drive_idle(64'h1000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pred_taken", {63'h0, bpu_if.o_riscv_bpu_pred_taken}, 64'h0);
    check("rst_mispredict", {63'h0, bpu_if.o_riscv_bpu_mispredict}, 64'h0);
    check("rst_correct_pc", bpu_if.o_riscv_bpu_correct_pc, 64'h0);
    rst_n = 1'b1;

    // Table-driven main sequence.
    for (int i = 0; i < NVEC; i++) begin
      bpu_if.i_riscv_bpu_fetch_pc        = vec[i].fetch_pc;
      bpu_if.i_riscv_bpu_upd_valid       = vec[i].upd_valid;
      bpu_if.i_riscv_bpu_upd_pc          = vec[i].upd_pc;
      bpu_if.i_riscv_bpu_upd_compressed  = vec[i].upd_compressed;
      bpu_if.i_riscv_bpu_upd_taken       = vec[i].upd_taken;
      bpu_if.i_riscv_bpu_upd_target      = vec[i].upd_target;
      bpu_if.i_riscv_bpu_upd_pred_taken  = vec[i].upd_pred_taken;
      bpu_if.i_riscv_bpu_upd_pred_target = vec[i].upd_pred_target;
      if (vec[i].upd_valid) exp_branches++;
      if (vec[i].exp_mispredict) exp_mispreds++;
      #1;
      check($sformatf("v%0d_pred_taken", i), {63'h0, bpu_if.o_riscv_bpu_pred_taken},
            {63'h0, vec[i].exp_pred_taken});
      check($sformatf("v%0d_pred_target", i), bpu_if.o_riscv_bpu_pred_target,
            vec[i].exp_pred_target);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_mispredict", i), {63'h0, bpu_if.o_riscv_bpu_mispredict},
            {63'h0, vec[i].exp_mispredict});
      check($sformatf("v%0d_correct_pc", i), bpu_if.o_riscv_bpu_correct_pc,
            vec[i].exp_correct_pc);
      @(negedge clk);
    end

`ifdef RISCV_BPU_STATS_EN
    check("stats_branch_cnt", {32'h0, bpu_if.o_riscv_bpu_branch_cnt}, 64'(exp_branches));
    check("stats_mispred_cnt", {32'h0, bpu_if.o_riscv_bpu_mispred_cnt}, 64'(exp_mispreds));
`endif

    // Mid-stream reset with a mispredict pending: raise a flush first.
    drive_idle(64'h3002);
    bpu_if.i_riscv_bpu_upd_valid       = 1'b1;
    bpu_if.i_riscv_bpu_upd_pc          = 64'h1000;
    bpu_if.i_riscv_bpu_upd_pred_taken  = 1'b1;
    bpu_if.i_riscv_bpu_upd_pred_target = 64'h2400;
    #1;
    check("pre_rst_pred_taken", {63'h0, bpu_if.o_riscv_bpu_pred_taken}, 64'h1);
    @(posedge clk);
    #1;
    check("pre_rst_mispredict", {63'h0, bpu_if.o_riscv_bpu_mispredict}, 64'h1);
    check("pre_rst_correct_pc", bpu_if.o_riscv_bpu_correct_pc, 64'h1004);
    @(negedge clk);
    drive_idle(64'h3002);
    rst_n = 1'b0;
    #1;
    check("in_rst_pred_taken", {63'h0, bpu_if.o_riscv_bpu_pred_taken}, 64'h0);
    check("in_rst_pred_target", bpu_if.o_riscv_bpu_pred_target, 64'h0);
    @(posedge clk);
    #1;
    check("post_rst_mispredict", {63'h0, bpu_if.o_riscv_bpu_mispredict}, 64'h0);
    check("post_rst_correct_pc", bpu_if.o_riscv_bpu_correct_pc, 64'h0);
`ifdef RISCV_BPU_STATS_EN
    check("post_rst_branch_cnt", {32'h0, bpu_if.o_riscv_bpu_branch_cnt}, 64'h0);
    check("post_rst_mispred_cnt", {32'h0, bpu_if.o_riscv_bpu_mispred_cnt}, 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle(64'h3002);
    #1;
    check("cleared_3002_taken", {63'h0, bpu_if.o_riscv_bpu_pred_taken}, 64'h0);
    drive_idle(64'h1000);
    #1;
    check("cleared_1000_taken", {63'h0, bpu_if.o_riscv_bpu_pred_taken}, 64'h0);
    check("cleared_1000_target", bpu_if.o_riscv_bpu_pred_target, 64'h0);
    @(posedge clk);
    #1;
    check("idle_mispredict", {63'h0, bpu_if.o_riscv_bpu_mispredict}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
